// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one combinational ALU between
// NREQ requesters. Operands are registered onto the ALU inputs, the result is
// captured one cycle later and returned with the requester ID.
// Optional build macro ALU_ARB_PERF_EN adds a saturating 16-bit op_count output.
module alu_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int SW   = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*SW-1:0] req_sel,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic [SW-1:0]      alu_sel,
    input  logic [DW-1:0]      alu_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_data,
    output logic               busy
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]        op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // NREQ expressed in the width used for pointer arithmetic (IDW+1 bits always holds it)
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           accept;

    logic [DW-1:0]  alu_a_q, alu_b_q, rsp_data_q;
    logic [SW-1:0]  alu_sel_q;
    logic [IDW-1:0] rsp_id_q;
    logic           rsp_valid_q;

    // Per-requester views of the packed operand buses
    logic [DW-1:0]  a_arr   [NREQ];
    logic [DW-1:0]  b_arr   [NREQ];
    logic [SW-1:0]  sel_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]   = req_a[gi*DW +: DW];
            assign b_arr[gi]   = req_b[gi*DW +: DW];
            assign sel_arr[gi] = req_sel[gi*SW +: SW];
        end
    endgenerate

    // Round-robin scan starting at rr_ptr; first valid requester wins
    always_comb begin
        logic [IDW:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    assign accept = (state_q == IDLE) && grant_found;

    // One-hot ready to the granted requester, only in IDLE and out of reset
    always_comb begin
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next state and next round-robin pointer (one past the winner, wrapping)
    always_comb begin
        logic [IDW:0] nxt;
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        nxt      = {1'b0, grant_idx} + (IDW+1)'(1);
        if (nxt == NREQ_W) begin
            nxt = '0;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = EXEC;
                    rr_ptr_d = nxt[IDW-1:0];
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and arbitration pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Operand capture on accept, result capture after the one-cycle ALU settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_q   <= a_arr[grant_idx];
                alu_b_q   <= b_arr[grant_idx];
                alu_sel_q <= sel_arr[grant_idx];
                rsp_id_q  <= grant_idx;
            end
            if (state_q == EXEC) begin
                rsp_data_q  <= alu_out;
                rsp_valid_q <= 1'b1;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [15:0] op_count_q;

    // Completed-op counter, saturating at all ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (rsp_valid_q && rsp_ready && (op_count_q != 16'hFFFF)) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q != IDLE);

endmodule
